shift_unit_arbiter: RTL
=======================

Name: shift_unit_arbiter

Overview:
Shares one 64-bit shift datapath (SLL/SRL/SRA) between NREQ requesters, e.g. two ALU issue slots.
- Round-robin arbitration with valid/ready handshake on every requester.
- Registered single-entry response stage, tagged with the requester ID.
- Sits between the issue logic and writeback, in place of per-slot shifters.

Parameters:
NREQ, 2, number of requesters (2..4)
IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  request valid, one bit per requester
req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
req_a  input  NREQ*64  operand per requester; slice i = [64*i+63:64*i]
req_b  input  NREQ*6  shift amount 0..63 per requester
req_op  input  NREQ*2  00 SLL, 01 SRL, 10 SRA, 11 reserved
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer accepts the response
rsp_data  output  64  shift result
rsp_id  output  IDW  index of the requester that produced rsp_data
rsp_err  output  1  request used reserved opcode 11
grant_count  output  NREQ*16  per-requester accepted-request counters (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, grant_count=0.
  - Round-robin pointer = 0.
  - Any held response is discarded.
  - req_ready=0 while rst=1.
- can_accept = !rsp_valid | rsp_ready (combinational).
- Arbitration (combinational):
  - Among asserted req_valid bits, grant the first index at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 only when can_accept and a grant exists; all other bits 0.
  - Does not depend on req_ready from the same cycle; no combinational loop via rsp_ready other than can_accept.
- Accept (req_valid[g] & req_ready[g]) at clk edge:
  - rsp_data <= shift(req_a[g], req_b[g], req_op[g]); rsp_id <= g; rsp_err <= (op==11); rsp_valid <= 1.
  - Pointer <= (g+1) mod NREQ.
- Pointer holds when nothing is accepted.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 per cycle while rsp_ready=1.
- Drain: rsp_valid & rsp_ready with no accept in the same cycle -> rsp_valid <= 0.
- Simultaneous drain and accept -> rsp_valid stays 1 and new data loads (back-to-back).
- Backpressure: while rsp_valid & !rsp_ready, rsp_data/rsp_id/rsp_err are held stable and all req_ready=0.
- Requesters must hold valid and payload stable until accepted. Dropping valid before acceptance is legal; the request is simply withdrawn.
- Shift arithmetic, amount b = 0..63:
  - SLL zero-fills from the LSB.
  - SRL zero-fills from the MSB.
  - SRA fills with a[63].
  - b=0 returns a unchanged.
  - Opcode 11: rsp_data = a unchanged, rsp_err=1.
- No request valid -> no state change except drain.
- Requester index >= NREQ never appears on rsp_id.

Optional Feature:
Macro SHIFT_ARB_STATS_EN.
- Defined:
  - grant_count slice i increments by 1 on each accept from requester i.
  - Saturates at 16'hFFFF with no wrap.
  - Cleared by rst.
- Undefined:
  - Counters are not built; grant_count is driven constant 0.
  - Port list is unchanged.

Test Plan:
- Single requester 0: a=64'hFFFFFFFFFFFFFF9C (-100), b=2, op=SRA -> next cycle rsp_valid=1, rsp_data=64'hFFFFFFFFFFFFFFE7 (-25), rsp_id=0, rsp_err=0.
- Both requesters valid continuously, rsp_ready=1; req0 SLL a=1 b=63, req1 SRL a=64'h8000000000000000 b=63:
  - grants alternate 0,1,0,1;
  - responses are 64'h8000000000000000 (id 0) and 64'h1 (id 1).
- Backpressure: hold rsp_ready=0 for 3 cycles with a result pending -> rsp_data/rsp_id stable, req_ready=0 throughout; on release, the next grant lands the cycle after drain.
- Edge amounts: SRA a=64'h8000000000000000 b=1 -> 64'hC000000000000000; SRA a=-1 b=63 -> -1; op=11 a=64'h1234 -> rsp_data=64'h1234, rsp_err=1.
- Reset mid-operation: assert rst while rsp_valid=1 and pointer=1 -> next cycle rsp_valid=0, outputs 0; first grant after reset with both requesters valid goes to requester 0.
- With SHIFT_ARB_STATS_EN, 5 accepts from req0 and 3 from req1 -> grant_count slice 0 = 5, slice 1 = 3. Without the macro -> grant_count = 0.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
//   One shared 64-bit shifter (SLL/SRL/SRA) serving NREQ requesters.
//   Requesters are picked round-robin, and the result goes into a single
//   registered response entry. That entry is tagged with the index of the
//   requester that produced it.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid    per-requester request valid            [NREQ]
//   req_ready    per-requester accept strobe (one-hot)  [NREQ]
//   req_a        per-requester operand, slice i = [64*i +: 64]
//   req_b        per-requester shift amount, slice i = [6*i +: 6]
//   req_op       per-requester opcode 00 SLL, 01 SRL, 10 SRA, 11 reserved
//   rsp_valid    response entry holds a result
//   rsp_ready    consumer takes the response
//   rsp_data     shift result
//   rsp_id       requester index that produced rsp_data
//   rsp_err      result came from reserved opcode 11 (data passes through)
//   grant_count  per-requester saturating accept counters, slice i = [16*i +: 16]
//
// Optional feature
//   SHIFT_ARB_STATS_EN  when defined, builds the grant counters.
//                       Otherwise grant_count is tied to 0.
//
// Handshake: a transfer happens on a clk edge where valid and ready are both 1.
//   A requester keeps valid and payload stable until it sees ready, and it may
//   drop valid to withdraw. req_ready never depends on req_ready itself. Its
//   only dependency on rsp_ready is through can_accept. The response side holds
//   data/id/err stable while rsp_valid & !rsp_ready.

module shift_unit_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*6-1:0]    req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic [NREQ*16-1:0]   grant_count
);

  logic [IDW-1:0]    r_ptr;
  logic              r_rsp_valid;
  logic [63:0]       r_rsp_data;
  logic [IDW-1:0]    r_rsp_id;
  logic              r_rsp_err;

  logic              w_found;
  logic [IDW-1:0]    w_gnt;
  logic [63:0]       w_a;
  logic [5:0]        w_b;
  logic [1:0]        w_op;
  logic [63:0]       w_res;
  logic signed [63:0] w_sra;
  logic              w_can_accept;
  logic              w_accept;
  int                w_idx;

  // Scan from the pointer upward and wrap around. The first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_a     = '0;
    w_b     = '0;
    w_op    = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
        w_a     = req_a[w_idx*64 +: 64];
        w_b     = req_b[w_idx*6 +: 6];
        w_op    = req_op[w_idx*2 +: 2];
      end
    end
  end

  assign w_sra = $signed(w_a) >>> w_b;

  always_comb begin
    case (w_op)
      2'b00:   w_res = w_a << w_b;
      2'b01:   w_res = w_a >> w_b;
      2'b10:   w_res = $unsigned(w_sra);
      default: w_res = w_a;  // reserved opcode passes the operand through
    endcase
  end

  // The entry can take new data if it is empty or is being drained this cycle.
  assign w_can_accept = !r_rsp_valid || rsp_ready;
  assign w_accept     = w_found && w_can_accept && !rst;
  assign req_ready    = w_accept ? (NREQ'(1) << w_gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      // This covers accept-only and also drain-plus-accept (back-to-back).
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_res;
      r_rsp_id    <= w_gnt;
      r_rsp_err   <= (w_op == 2'b11);
      r_ptr       <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] r_cnt [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i] && r_cnt[i] != 16'hFFFF)
          r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NREQ; i++) grant_count[16*i +: 16] = r_cnt[i];
  end
`else
  assign grant_count = '0;
`endif

endmodule
